// File: rtl/encrypt_fsm_pkg.sv
// Shared constants, state encoding and DES permutation/S-box helpers for the
// iterative encryptor. All tables use the DES convention: entries are
// 1-based bit positions counted from the MSB of the source word.
package encrypt_fsm_pkg;

   localparam int N_K        = 64;
   localparam int N_B        = 64;
   localparam int ROUND_BITS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   // left-rotate amount for C/D before each round's subkey
   localparam logic [1:0] SHIFT [0:15] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   localparam int IP_T [0:63] = '{
      58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
      62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
      57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
      61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};

   localparam int FP_T [0:63] = '{
      40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
      38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
      36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
      34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};

   localparam int E_T [0:47] = '{
      32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
      12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
      24,25,26,27,28,29, 28,29,30,31,32, 1};

   localparam int P_T [0:31] = '{
      16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
       2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};

   localparam int PC1_T [0:55] = '{
      57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
      10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
      63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
      14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};

   localparam int PC2_T [0:47] = '{
      14,17,11,24, 1, 5, 3,28,15, 6,21,10,
      23,19,12, 4,26, 8,16, 7,27,20,13, 2,
      41,52,31,37,47,55,30,40,51,45,33,48,
      44,49,39,56,34,53,46,42,50,36,29,32};

   // S-boxes, each indexed by {row, col} = {b1 b6, b2..b5}
   localparam logic [3:0] SBOX [0:7][0:63] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y = '0;
      for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_e(input logic [31:0] x);
      logic [47:0] y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      logic [31:0] y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] sbox_sub(input logic [47:0] x);
      logic [31:0] y = '0;
      logic [5:0]  six;
      for (int b = 0; b < 8; b++) begin
         six = x[47-6*b -: 6];
         y[31-4*b -: 4] = SBOX[b][{six[5], six[0], six[4:1]}];
      end
      return y;
   endfunction

endpackage

// File: rtl/encrypt_fsm_des_round.sv
// One DES round, purely combinational (the shared des_round datapath).
//   l, r        : current Feistel halves
//   kc, kd      : current 28-bit key halves (pre-rotation)
//   shift       : rotate amount for this round (1 or 2)
//   l_nxt..kd_nxt : state after the round; the rotated key halves are
//                   returned so the next round continues from them
module encrypt_fsm_des_round
   import encrypt_fsm_pkg::*;
(
   input  logic [31:0] l,
   input  logic [31:0] r,
   input  logic [27:0] kc,
   input  logic [27:0] kd,
   input  logic [1:0]  shift,
   output logic [31:0] l_nxt,
   output logic [31:0] r_nxt,
   output logic [27:0] kc_nxt,
   output logic [27:0] kd_nxt
);

   logic [47:0] subkey;
   logic [31:0] f_out;

   // only 1 and 2 occur in the schedule
   assign kc_nxt = (shift == 2'd2) ? {kc[25:0], kc[27:26]} : {kc[26:0], kc[27]};
   assign kd_nxt = (shift == 2'd2) ? {kd[25:0], kd[27:26]} : {kd[26:0], kd[27]};

   assign subkey = perm_pc2({kc_nxt, kd_nxt});
   assign f_out  = perm_p(sbox_sub(perm_e(r) ^ subkey));

   assign l_nxt = r;
   assign r_nxt = l ^ f_out;

endmodule

// File: rtl/encrypt_fsm.sv
// Iterative DES encryptor: one round per clock through a single shared
// round datapath, four-phase req/ack host handshake.
//   clk  : clock          rst  : async reset, active low
//   req  : host request   ack  : result valid (registered), held until req=0
//   k, m : key/plaintext, sampled on the accepting edge only
//   c    : ciphertext, registered, updated only on the completing edge
//   busy : high while rounds are running
// Only the 64-bit, 16-round configuration is supported.
module encrypt_fsm
   import encrypt_fsm_pkg::*;
#(
   parameter int N_K    = 64,
   parameter int N_B    = 64,
   parameter int ROUNDS = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req,
   output logic           ack,
   input  logic [N_K-1:0] k,
   input  logic [N_B-1:0] m,
   output logic [N_B-1:0] c,
   output logic           busy
);

   localparam logic [ROUND_BITS-1:0] LAST = ROUND_BITS'(ROUNDS - 1);

   state_t                state;
   logic [ROUND_BITS-1:0] rnd;
   logic [31:0]           half_l, half_r;
   logic [27:0]           key_c, key_d;

   logic [31:0]           l_nxt, r_nxt;
   logic [27:0]           kc_nxt, kd_nxt;
   logic [63:0]           ip_m;
   logic [55:0]           pc1_k;

   assign ip_m  = perm_ip(m);
   assign pc1_k = perm_pc1(k);

   encrypt_fsm_des_round u_round (
      .l      (half_l),
      .r      (half_r),
      .kc     (key_c),
      .kd     (key_d),
      .shift  (SHIFT[rnd]),
      .l_nxt  (l_nxt),
      .r_nxt  (r_nxt),
      .kc_nxt (kc_nxt),
      .kd_nxt (kd_nxt)
   );

   assign busy = (state == ROUND);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         ack    <= 1'b0;
         c      <= '0;
         rnd    <= '0;
         half_l <= '0;
         half_r <= '0;
         key_c  <= '0;
         key_d  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // DONE is left only with req low, so a req seen here is
               // always a fresh request
               if (req) begin
                  {half_l, half_r} <= ip_m;
                  {key_c, key_d}   <= pc1_k;
                  rnd              <= '0;
                  state            <= ROUND;
               end
            end
            ROUND: begin
               half_l <= l_nxt;
               half_r <= r_nxt;
               key_c  <= kc_nxt;
               key_d  <= kd_nxt;
               if (rnd == LAST) begin
                  // preoutput is R16||L16 (final swap undone)
                  c     <= N_B'(perm_fp({r_nxt, l_nxt}));
                  ack   <= 1'b1;
                  state <= DONE;
               end else begin
                  rnd <= rnd + 1'b1;
               end
            end
            DONE: begin
               if (!req) begin
                  ack   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               ack   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encrypt_fsm.sv
module tb_encrypt_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        ack;
   logic [63:0] k_i = '0;
   logic [63:0] m_i = '0;
   logic [63:0] c;
   logic        busy;

   int checks = 0;
   int errors = 0;

   encrypt_fsm #(.N_K(64), .N_B(64), .ROUNDS(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .ack  (ack),
      .k    (k_i),
      .m    (m_i),
      .c    (c),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [63:0] k;
      logic [63:0] m;
      logic [63:0] c;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge. Raises req, then samples on each negedge until ack
   // or a 40-edge budget runs out. Returns with req left as driven.
   task automatic do_op(input vec_t v, input bit early_drop, input bit scramble);
      int edges = 0;
      int busy_cnt = 0;
      k_i = v.k;
      m_i = v.m;
      req = 1'b1;
      while (edges < 40) begin
         @(negedge clk);
         edges++;
         if (early_drop) req = 1'b0;
         if (scramble) begin
            k_i = {$urandom(), $urandom()};
            m_i = {$urandom(), $urandom()};
         end
         if (busy) busy_cnt++;
         if (ack) break;
      end
      chk({v.name, " latency"}, 64'(edges), 64'd17);
      chk({v.name, " busy cycles"}, 64'(busy_cnt), 64'd16);
      chk({v.name, " c"}, c, v.c);
   endtask

   // hold req high a few cycles, then release and check ack falls, c holds
   task automatic hold_release(input vec_t v);
      repeat (3) begin
         @(negedge clk);
         chk({v.name, " held ack"}, 64'(ack), 64'd1);
         chk({v.name, " held busy"}, 64'(busy), 64'd0);
      end
      req = 1'b0;
      @(negedge clk);
      chk({v.name, " ack fall"}, 64'(ack), 64'd0);
      chk({v.name, " c hold"}, c, v.c);
   endtask

   initial begin
      vecs[0] = '{"zero",   64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
      vecs[1] = '{"to_zero",64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000};
      vecs[2] = '{"now_is", 64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815};
      vecs[3] = '{"kat",    64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};

      repeat (2) @(negedge clk);
      chk("reset ack", 64'(ack), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset c", c, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // back-to-back: req is low for exactly one cycle between operations
      for (int i = 0; i < 4; i++) begin
         do_op(vecs[i], 1'b0, 1'b0);
         hold_release(vecs[i]);
      end

      // single-cycle req: ack must be a one-cycle pulse
      do_op(vecs[0], 1'b1, 1'b0);
      @(negedge clk);
      chk("early drop ack pulse", 64'(ack), 64'd0);
      chk("early drop c hold", c, vecs[0].c);

      // inputs change every cycle after acceptance
      do_op(vecs[2], 1'b0, 1'b1);
      hold_release(vecs[2]);

      // start kat so c changes, then abort mid-run with async reset
      do_op(vecs[3], 1'b0, 1'b0);
      req = 1'b0;
      @(negedge clk);
      k_i = vecs[2].k;
      m_i = vecs[2].m;
      req = 1'b1;
      repeat (8) @(negedge clk);
      chk("mid-run busy", 64'(busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort ack", 64'(ack), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort c", c, 64'd0);
      req = 1'b0;
      @(negedge clk);
      chk("abort c still clear", c, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      do_op(vecs[3], 1'b0, 1'b0);
      hold_release(vecs[3]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/encrypt_fsm.md
Name: encrypt_fsm

Overview:
- Iterative, multi-cycle DES encryption controller.
- Captures key and plaintext under a req/ack four-phase handshake, then applies the initial permutations (IP on m, PC1 on k).
- Sequences 16 Feistel rounds through one shared combinational round datapath (one round per clock), applies the final permutation and presents c.
- Replaces the fully unrolled combinational encryptor where area matters; sits between the host interface and the existing permutation/S-box library.

Parameters:
- N_K, 64: cipher key width (matches `N_K).
- N_B, 64: block width (matches `N_B).
- ROUNDS, 16: Feistel round count; only 16 is supported.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: reset; asynchronous, active-low.
- req, input, 1: host request; four-phase handshake.
- ack, output, 1: completion acknowledge; registered.
- k, input, N_K: cipher key; sampled only at request acceptance.
- m, input, N_B: plaintext; sampled only at request acceptance.
- c, output, N_B: ciphertext; registered, held between operations.
- busy, output, 1: high while rounds are in progress (state ROUND).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ack=0, busy=0, c=0, rnd=0.
  - L, R, C, D registers cleared.
  - Reset mid-operation aborts it; no partial result reaches c.
- State IDLE: on a rising edge with req=1:
  - L||R <= IP(m); C||D <= PC1(k) (28+28 bits).
  - rnd <= 0; go to ROUND.
- State ROUND, each edge:
  - Key rotation: C, D rotate left by SHIFT[rnd], with SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Subkey: K = PC2(rotated C||D).
  - Feistel step: L <= R; R <= L ^ f(R, K), where f = E-expand, XOR K, S-boxes, P.
  - rnd <= rnd+1.
  - On the edge where rnd=15: c <= FP(R16||L16) (halves swapped before FP) and go to DONE.
- State DONE: ack=1, busy=0.
  - Leave to IDLE on the first edge where req=0; ack falls on that same edge.
- Latency: ack is first seen high after the 17th rising edge, counting the req-sampling edge as edge 1 (1 load + 16 rounds).
- A new request needs req to go low and then high again; a held-high req never starts a second operation.
- req dropping during ROUND is ignored; the operation completes and DONE is entered. With req already 0, ack is high for exactly one cycle.
- k and m may change freely after the accepting edge without affecting the result.
- c changes only on the completing edge; it holds its last value through IDLE and the next ROUND.
- rnd is 4 bits and saturates in meaning: it is reset to 0 on each accept and never wraps inside an operation.
- busy is combinationally decoded from the state register, which is glitch-free relative to clk.

Decomposition:
- params.h: add the SHIFT schedule (16 × 2-bit constant), state encodings (IDLE/ROUND/DONE, 2 bits) and ROUND_BITS=4, alongside the existing `N_K / `N_B.
- Sub-module des_round (combinational, one instance):
  - Inputs L, R, C, D, shift amount. Outputs next L, R, C, D.
  - Built from the existing E, PC2, S-box and P permutation modules.
- The FSM, counter and registers stay in encrypt_fsm. IP, PC1 and FP reuse the existing perm_IP, perm_PC1 and perm_FP instances.

Test Plan:
- Known-answer: k=0x133457799BBCDFF1, m=0x0123456789ABCDEF, req pulse held -> ack high at edge 17; c=0x85E813540F0AB405; busy high for exactly 16 cycles.
- Zero vector: k=0, m=0 -> c=0x8CA64DE9C1B123A7. Then k=0x0E329232EA6D0D73, m=0x8787878787878787 back-to-back (req low for one cycle between) -> c=0x0000000000000000.
- Handshake:
  - Hold req=1 after ack: ack stays 1 and no second operation starts.
  - Drop req: ack falls the next edge; c is held.
  - Early drop: req high for one cycle only -> ack is a one-cycle pulse at edge 17 with the correct c.
- Input stability: change k and m to random values every cycle after acceptance -> c still equals the value computed from the sampled k and m.
- Reset: assert rst=0 asynchronously (mid-cycle) at round 7 -> ack=0, busy=0, c=0 immediately. After release, a fresh known-answer request completes correctly in 17 edges.
